// File: rtl/swd_host_ctrl.sv
// SWD host initiator: runs one DP/AP request packet (or, with SWD_LINE_RESET_EN
// defined, a line-reset sequence) on SWCLK/SWDO/SWDOEN and returns ACK/read data.
module swd_host_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int IDLE_CYC = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_apndp,
  input  logic        cmd_rnw,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic        cmd_line_reset,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_parity_err,
  output logic        SWCLK,
  output logic        SWDO,
  output logic        SWDOEN,
  input  logic        SWDI
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [2:0] ACK_OK = 3'b001;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_TRN1, S_ACK, S_RDATA, S_TRN2, S_WDATA, S_TAIL
`ifdef SWD_LINE_RESET_EN
    , S_LRST
`endif
  } state_e;

  localparam state_e TAIL_NEXT = (IDLE_CYC == 0) ? S_IDLE : S_TAIL;

  state_e      state_q, state_d;
  logic [5:0]  bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic        swclk_q, swclk_d, swdo_q, swdo_d, swdoen_q, swdoen_d;
  logic        ready_q, ready_d;
  logic        apndp_q, apndp_d, rnw_q, rnw_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  ack_q, ack_d;
  logic        perr_q, perr_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_perr_q, rsp_perr_d;
  logic [2:0]  rsp_ack_q, rsp_ack_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        accept, phase_end, bit_end;
  logic [2:0]  ack_now;
  logic [7:0]  req_vec;

`ifndef SWD_LINE_RESET_EN
  logic unused_line_reset;
  assign unused_line_reset = cmd_line_reset;
`endif

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    div_d       = div_q;
    swclk_d     = swclk_q;
    swdo_d      = swdo_q;
    swdoen_d    = swdoen_q;
    apndp_d     = apndp_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ack_d       = ack_q;
    perr_d      = perr_q;
    rsp_valid_d = 1'b0;
    rsp_ack_d   = rsp_ack_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_perr_d  = rsp_perr_q;
    accept      = ready_q && cmd_valid && (state_q == S_IDLE);
    phase_end   = (div_q == DIV_LAST);
    bit_end     = swclk_q && phase_end;
    ack_now     = {SWDI, ack_q[2:1]};

    if (state_q == S_IDLE) begin
      if (accept) begin
        apndp_d = cmd_apndp;
        rnw_d   = cmd_rnw;
        addr_d  = cmd_addr;
        data_d  = cmd_wdata;
        ack_d   = 3'b000;
        perr_d  = 1'b0;
        bit_d   = 6'd0;
        div_d   = '0;
        swclk_d = 1'b0;
        state_d = S_REQ;
`ifdef SWD_LINE_RESET_EN
        if (cmd_line_reset) state_d = S_LRST;
`endif
      end
    end else begin
      div_d = phase_end ? '0 : div_q + 1'b1;
      if (phase_end) swclk_d = ~swclk_q;
      // All bit-level decisions happen on the final HCLK of the high phase,
      // which is also where SWDI is sampled.
      if (bit_end) begin
        bit_d = bit_q + 6'd1;
        case (state_q)
          S_REQ: if (bit_q == 6'd7) begin state_d = S_TRN1; bit_d = 6'd0; end
          S_TRN1: begin state_d = S_ACK; bit_d = 6'd0; end
          S_ACK: begin
            ack_d = ack_now;
            if (bit_q == 6'd2) begin
              bit_d   = 6'd0;
              state_d = (ack_now == ACK_OK && rnw_q) ? S_RDATA : S_TRN2;
            end
          end
          S_RDATA: begin
            if (bit_q < 6'd32) begin
              data_d = {SWDI, data_q[31:1]};
            end else begin
              perr_d  = SWDI ^ (^data_q);
              state_d = S_TRN2;
              bit_d   = 6'd0;
            end
          end
          S_TRN2: begin
            bit_d   = 6'd0;
            state_d = (ack_q == ACK_OK && !rnw_q) ? S_WDATA : TAIL_NEXT;
          end
          S_WDATA: if (bit_q == 6'd32) begin state_d = TAIL_NEXT; bit_d = 6'd0; end
          S_TAIL: if (bit_q == 6'(IDLE_CYC - 1)) begin state_d = S_IDLE; bit_d = 6'd0; end
`ifdef SWD_LINE_RESET_EN
          S_LRST: if (bit_q == 6'd53) begin state_d = S_IDLE; bit_d = 6'd0; end
`endif
          default: begin state_d = S_IDLE; bit_d = 6'd0; end
        endcase
      end
    end

    // Request bits, LSB first: start, APnDP, RnW, A2, A3, parity, stop, park.
    req_vec = {1'b1, 1'b0, apndp_d ^ rnw_d ^ addr_d[0] ^ addr_d[1],
               addr_d[1], addr_d[0], rnw_d, apndp_d, 1'b1};

    if (accept || bit_end) begin
      swdo_d   = 1'b0;
      swdoen_d = 1'b1;
      case (state_d)
        S_REQ:                 swdo_d = req_vec[bit_d[2:0]];
        S_TRN1, S_ACK, S_RDATA: swdoen_d = 1'b0;
        S_WDATA:               swdo_d = (bit_d == 6'd32) ? ^data_d : data_d[bit_d[4:0]];
`ifdef SWD_LINE_RESET_EN
        S_LRST:                swdo_d = (bit_d < 6'd52);
`endif
        default: ;
      endcase
    end

    if (state_q != S_IDLE && state_d == S_IDLE) begin
      rsp_valid_d = 1'b1;
      rsp_ack_d   = ack_q;
      rsp_rdata_d = (rnw_q && ack_q == ACK_OK) ? data_q : 32'd0;
      rsp_perr_d  = perr_q;
    end
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      bit_q       <= 6'd0;
      div_q       <= '0;
      swclk_q     <= 1'b0;
      swdo_q      <= 1'b0;
      swdoen_q    <= 1'b1;
      ready_q     <= 1'b0;
      apndp_q     <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= 2'd0;
      data_q      <= 32'd0;
      ack_q       <= 3'd0;
      perr_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ack_q   <= 3'd0;
      rsp_rdata_q <= 32'd0;
      rsp_perr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      swclk_q     <= swclk_d;
      swdo_q      <= swdo_d;
      swdoen_q    <= swdoen_d;
      ready_q     <= ready_d;
      apndp_q     <= apndp_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      perr_q      <= perr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ack_q   <= rsp_ack_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_perr_q  <= rsp_perr_d;
    end
  end

  assign cmd_ready      = ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_ack        = rsp_ack_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_parity_err = rsp_perr_q;
  assign SWCLK          = swclk_q;
  assign SWDO           = swdo_q;
  assign SWDOEN         = swdoen_q;

endmodule

// File: tb/tb_swd_host_ctrl.sv
// Directed bench for swd_host_ctrl with a bit-level SWD target model on SWCLK rising edges.
module tb_swd_host_ctrl;
  logic        HCLK = 1'b0, HRESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_apndp = 1'b0, cmd_rnw = 1'b0, cmd_line_reset = 1'b0;
  logic [1:0]  cmd_addr = 2'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        SWDI = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_parity_err, SWCLK, SWDO, SWDOEN;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;

  swd_host_ctrl #(.CLK_DIV(4), .IDLE_CYC(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_apndp(cmd_apndp), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_line_reset(cmd_line_reset), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
    .rsp_rdata(rsp_rdata), .rsp_parity_err(rsp_parity_err), .SWCLK(SWCLK),
    .SWDO(SWDO), .SWDOEN(SWDOEN), .SWDI(SWDI)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0, errors = 0;
  logic tgt_bits [0:127];
  logic swdo_log [0:127];
  logic oen_log  [0:127];
  int   edge_cnt = 0, base = 0, rsp_cnt = 0, mon_rel = 0;
  logic swclk_prev = 1'b0;
  logic [2:0]  r_ack;
  logic [31:0] r_rdata;
  logic        r_perr;
  int          nbits;

  // Target model: on each SWCLK rising edge log the host pins and present the next SWDI bit.
  always @(negedge HCLK) begin
    if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    if (SWCLK && !swclk_prev) begin
      mon_rel = edge_cnt - base;
      if (mon_rel >= 0 && mon_rel < 128) begin
        swdo_log[mon_rel] = SWDO;
        oen_log[mon_rel]  = SWDOEN;
        SWDI = tgt_bits[mon_rel];
      end
      edge_cnt = edge_cnt + 1;
    end
    swclk_prev = SWCLK;
  end

  function automatic logic [7:0] req_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = swdo_log[i];
    return b;
  endfunction

  function automatic logic [31:0] log_word(input int off);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = swdo_log[off + i];
    return w;
  endfunction

  task automatic set_target(input logic [2:0] ack, input logic [31:0] data, input logic par);
    for (int i = 0; i < 128; i++) tgt_bits[i] = 1'b0;
    for (int i = 0; i < 3; i++) tgt_bits[9 + i] = ack[i];
    for (int i = 0; i < 32; i++) tgt_bits[12 + i] = data[i];
    tgt_bits[44] = par;
  endtask

  task automatic send_cmd(input logic ap, input logic rnw, input logic [1:0] addr,
                          input logic [31:0] wd, input logic lr);
    @(posedge HCLK); #1;
    cmd_apndp = ap; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd; cmd_line_reset = lr;
    cmd_valid = 1'b1;
    base = edge_cnt;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_drop got %b want 0", cmd_ready); end
  endtask

  task automatic wait_rsp(input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge HCLK);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s rsp_timeout got none want rsp_valid", name);
    end else begin
      r_ack = rsp_ack; r_rdata = rsp_rdata; r_perr = rsp_parity_err; nbits = edge_cnt - base;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s ready_with_rsp got %b want 1", name, cmd_ready); end
      @(negedge HCLK);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s rsp_pulse got %b want 0", name, rsp_valid); end
    end
    $display("txn %s ack=%b rdata=%h perr=%b bits=%0d", name, r_ack, r_rdata, r_perr, nbits);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge HCLK);
    #1;
    checks++;
    if ({SWCLK, SWDO, SWDOEN, cmd_ready, rsp_valid} !== 5'b00100) begin
      errors++; $display("FAIL reset_pins got %b want 00100", {SWCLK, SWDO, SWDOEN, cmd_ready, rsp_valid});
    end
    checks++;
    if ({rsp_ack, rsp_rdata, rsp_parity_err} !== 36'd0) begin
      errors++; $display("FAIL reset_rsp got %h want 0", {rsp_ack, rsp_rdata, rsp_parity_err});
    end
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", cmd_ready); end
    $display("txn reset");
  endtask

  task automatic test_dp_read();
    set_target(3'b001, 32'h2BA01477, 1'b0);
    send_cmd(1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
    wait_rsp("dp_read");
    checks++; if (req_byte() !== 8'hA5) begin errors++; $display("FAIL rd_req got %h want a5", req_byte()); end
    checks++; if (r_ack !== 3'b001) begin errors++; $display("FAIL rd_ack got %b want 001", r_ack); end
    checks++; if (r_rdata !== 32'h2BA01477) begin errors++; $display("FAIL rd_data got %h want 2ba01477", r_rdata); end
    checks++; if (r_perr !== 1'b0) begin errors++; $display("FAIL rd_perr got %b want 0", r_perr); end
    checks++; if (nbits != 54) begin errors++; $display("FAIL rd_bits got %0d want 54", nbits); end
    checks++;
    if ({oen_log[3], oen_log[8], oen_log[10], oen_log[30], oen_log[45], oen_log[50], swdo_log[50]} !== 7'b1000110) begin
      errors++; $display("FAIL rd_oen got %b want 1000110",
        {oen_log[3], oen_log[8], oen_log[10], oen_log[30], oen_log[45], oen_log[50], swdo_log[50]});
    end
  endtask

  task automatic test_dp_write();
    set_target(3'b001, 32'd0, 1'b0);
    send_cmd(1'b0, 1'b0, 2'd0, 32'h0000001E, 1'b0);
    wait_rsp("dp_write");
    checks++; if (req_byte() !== 8'h81) begin errors++; $display("FAIL wr_req got %h want 81", req_byte()); end
    checks++; if (log_word(13) !== 32'h0000001E) begin errors++; $display("FAIL wr_data got %h want 0000001e", log_word(13)); end
    checks++; if (swdo_log[45] !== 1'b0) begin errors++; $display("FAIL wr_par got %b want 0", swdo_log[45]); end
    checks++; if ({oen_log[11], oen_log[12], oen_log[13]} !== 3'b011) begin
      errors++; $display("FAIL wr_oen got %b want 011", {oen_log[11], oen_log[12], oen_log[13]}); end
    checks++; if ({r_ack, r_rdata} !== {3'b001, 32'd0}) begin
      errors++; $display("FAIL wr_rsp got %b/%h want 001/00000000", r_ack, r_rdata); end
    checks++; if (nbits != 54) begin errors++; $display("FAIL wr_bits got %0d want 54", nbits); end
  endtask

  task automatic test_wait_ack();
    set_target(3'b010, 32'hFFFFFFFF, 1'b0);
    send_cmd(1'b1, 1'b1, 2'd3, 32'd0, 1'b0);
    wait_rsp("ap_wait");
    checks++; if (req_byte() !== 8'h9F) begin errors++; $display("FAIL wait_req got %h want 9f", req_byte()); end
    checks++; if ({r_ack, r_rdata} !== {3'b010, 32'd0}) begin
      errors++; $display("FAIL wait_rsp got %b/%h want 010/00000000", r_ack, r_rdata); end
    checks++; if (nbits != 21) begin errors++; $display("FAIL wait_bits got %0d want 21", nbits); end
  endtask

  task automatic test_parity_err();
    set_target(3'b001, 32'h12345678, 1'b0);
    send_cmd(1'b0, 1'b1, 2'd1, 32'd0, 1'b0);
    wait_rsp("par_err");
    checks++; if (req_byte() !== 8'h8D) begin errors++; $display("FAIL pe_req got %h want 8d", req_byte()); end
    checks++; if ({r_perr, r_rdata} !== {1'b1, 32'h12345678}) begin
      errors++; $display("FAIL pe_rsp got %b/%h want 1/12345678", r_perr, r_rdata); end
  endtask

  task automatic test_reset_mid_packet();
    int rc, ec;
    logic hit;
    set_target(3'b001, 32'hCAFEF00D, 1'b0);
    send_cmd(1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge HCLK);
      if (edge_cnt - base >= 23) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_timeout got %0d want 23", edge_cnt - base); end
    HRESET = 1'b1;
    rc = rsp_cnt;
    @(posedge HCLK); #1;
    checks++;
    if ({SWCLK, SWDO, SWDOEN, cmd_ready} !== 4'b0010) begin
      errors++; $display("FAIL mid_reset_pins got %b want 0010", {SWCLK, SWDO, SWDOEN, cmd_ready});
    end
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    ec = edge_cnt;
    repeat (600) @(posedge HCLK);
    #1;
    checks++;
    if (rsp_cnt != rc || edge_cnt != ec) begin
      errors++; $display("FAIL mid_abandon got rsp=%0d edges=%0d want rsp=%0d edges=%0d", rsp_cnt, edge_cnt, rc, ec);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", cmd_ready); end
    $display("txn reset_mid_packet rsp_count=%0d", rsp_cnt);
  endtask

  task automatic test_busy_ignore();
    int rc, ec;
    set_target(3'b001, 32'd0, 1'b0);
    send_cmd(1'b0, 1'b0, 2'd2, 32'hA5A5F00F, 1'b0);
    repeat (100) @(posedge HCLK);
    #1 cmd_valid = 1'b1; cmd_rnw = 1'b1;
    repeat (20) @(posedge HCLK);
    #1 cmd_valid = 1'b0;
    wait_rsp("busy_write");
    checks++; if (req_byte() !== 8'hB1) begin errors++; $display("FAIL busy_req got %h want b1", req_byte()); end
    checks++; if ({log_word(13), swdo_log[45]} !== {32'hA5A5F00F, 1'b0}) begin
      errors++; $display("FAIL busy_wdata got %h want a5a5f00f0", {log_word(13), swdo_log[45]}); end
    rc = rsp_cnt; ec = edge_cnt;
    repeat (100) @(posedge HCLK);
    #1;
    checks++;
    if (rsp_cnt != rc || edge_cnt != ec || nbits != 54) begin
      errors++; $display("FAIL busy_queued got rsp=%0d edges=%0d bits=%0d want rsp=%0d edges=%0d bits=54",
                         rsp_cnt, edge_cnt, nbits, rc, ec);
    end
  endtask

  task automatic test_line_reset();
    int ones;
    set_target(3'b001, 32'h2BA01477, 1'b0);
    send_cmd(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    wait_rsp("line_reset");
    checks++; if (nbits != 54) begin errors++; $display("FAIL lr_bits got %0d want 54", nbits); end
`ifdef SWD_LINE_RESET_EN
    ones = 0;
    for (int i = 0; i < 52; i++) if (swdo_log[i] === 1'b1 && oen_log[i] === 1'b1) ones++;
    checks++;
    if (ones != 52 || swdo_log[52] !== 1'b0 || swdo_log[53] !== 1'b0) begin
      errors++; $display("FAIL lr_pattern got ones=%0d tail=%b%b want ones=52 tail=00", ones, swdo_log[52], swdo_log[53]);
    end
    checks++; if ({r_ack, r_rdata} !== 35'd0) begin
      errors++; $display("FAIL lr_rsp got %b/%h want 000/00000000", r_ack, r_rdata); end
`else
    ones = 0;
    checks++; if (req_byte() !== 8'hA5) begin errors++; $display("FAIL lr_req got %h want a5", req_byte()); end
    checks++; if ({r_ack, r_rdata} !== {3'b001, 32'h2BA01477}) begin
      errors++; $display("FAIL lr_rsp got %b/%h want 001/2ba01477", r_ack, r_rdata); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin tgt_bits[i] = 1'b0; swdo_log[i] = 1'b0; oen_log[i] = 1'b0; end
    test_reset();
    test_dp_read();
    test_dp_write();
    test_wait_ack();
    test_parity_err();
    test_reset_mid_packet();
    test_busy_ignore();
    test_line_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
